// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALTED
   } fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// Program counter with boot load and wrapping word step, plus a saturating count of accepted instructions.
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W+1:0] BOOT_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [ADDR_W+1:0] pc,
   output logic [15:0]       count
);

   // Byte address width is exact, so stepping past the last word wraps to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= BOOT_ADDR;
      end else if (load) begin
         pc <= BOOT_ADDR;
      end else if (step) begin
         pc <= pc + (ADDR_W+2)'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (step && count != 16'hFFFF) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: single-outstanding reads from a 1-cycle synchronous instruction memory,
// each word presented on valid/ready; stops on a halt sentinel or an external stop.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W+1:0] BOOT_ADDR = '0,
   parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   output logic               mem_rd,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [ADDR_W+1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic [15:0]        instr_count
);

   fetch_state_t state, state_nxt;
   logic stop_pend;
   logic accept;
   logic pc_load;
   logic is_halt;

   assign is_halt = (mem_data == HALT_INSTR);
   assign accept  = (state == HOLD) && instr_ready;
   assign pc_load = start && (((state == IDLE) && !stop) || (state == HALTED));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !stop) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    state_nxt = is_halt ? HALTED : HOLD;
         HOLD:    if (accept) state_nxt = (stop_pend || stop) ? IDLE : REQ;
         HALTED:  if (start) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A stop seen mid-fetch is remembered so the presented word still completes first.
   always_ff @(posedge clk) begin
      if (rst) begin
         stop_pend <= 1'b0;
      end else if (state_nxt == IDLE) begin
         stop_pend <= 1'b0;
      end else if (busy && stop) begin
         stop_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr <= '0;
      end else if (state == WAIT && !is_halt) begin
         instr <= mem_data;
      end
   end

   fetch_pc #(
      .ADDR_W    (ADDR_W),
      .BOOT_ADDR (BOOT_ADDR)
   ) u_pc (
      .clk   (clk),
      .rst   (rst),
      .load  (pc_load),
      .step  (accept),
      .pc    (pc),
      .count (instr_count)
   );

   assign mem_rd      = (state == REQ);
   assign mem_addr    = pc[ADDR_W+1:2];
   assign instr_valid = (state == HOLD);
   assign busy        = (state == REQ) || (state == WAIT) || (state == HOLD);
   assign halted      = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main DUT at ADDR_W=8, a second instance at ADDR_W=2 for PC wrap.
module tb_instr_fetch;
   localparam logic [31:0] I0   = 32'h012A_4020;
   localparam logic [31:0] I1   = 32'h0109_5022;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        ready = 1'b1;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [9:0]  pc;
   logic        busy;
   logic        halted;
   logic [15:0] instr_count;

   logic        w_start = 1'b0;
   logic        w_stop = 1'b0;
   logic        w_ready = 1'b1;
   logic        w_mem_rd;
   logic [1:0]  w_mem_addr;
   logic [31:0] w_mem_data = '0;
   logic [31:0] w_instr;
   logic        w_valid;
   logic [3:0]  w_pc;
   logic        w_busy;
   logic        w_halted;
   logic [15:0] w_count;

   logic [31:0] mem  [0:255];
   logic [31:0] wmem [0:3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
   always @(posedge clk) if (w_mem_rd) w_mem_data <= wmem[w_mem_addr];

   instr_fetch #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(ready),
      .pc(pc), .busy(busy), .halted(halted), .instr_count(instr_count)
   );

   instr_fetch #(.ADDR_W(2)) u_wrap (
      .clk(clk), .rst(rst), .start(w_start), .stop(w_stop),
      .mem_rd(w_mem_rd), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
      .instr(w_instr), .instr_valid(w_valid), .instr_ready(w_ready),
      .pc(w_pc), .busy(w_busy), .halted(w_halted), .instr_count(w_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1; w_start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if ({mem_rd, instr_valid, busy, halted} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {mem_rd, instr_valid, busy, halted}); end
      n_cmp++; if (pc !== 10'd0 || mem_addr !== 8'd0) begin
         n_bad++; $display("FAIL reset_pc: got pc=%h addr=%h want 0/0", pc, mem_addr); end
      n_cmp++; if (instr !== 32'd0 || instr_count !== 16'd0) begin
         n_bad++; $display("FAIL reset_instr_count: got instr=%h cnt=%0d want 0/0", instr, instr_count); end
   endtask

   task automatic test_basic();
      do_reset();
      start = 1'b1;
      tick();                                   // T1
      start = 1'b0;
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'd0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL basic_T1_rd: got rd=%b addr=%h busy=%b want 1/00/1", mem_rd, mem_addr, busy); end
      tick();                                   // T2
      n_cmp++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
         n_bad++; $display("FAIL basic_T2: got rd=%b vld=%b want 0/0", mem_rd, instr_valid); end
      tick();                                   // T3
      n_cmp++; if (instr_valid !== 1'b1 || instr !== I0 || pc !== 10'd0) begin
         n_bad++; $display("FAIL basic_T3_word0: got vld=%b instr=%h pc=%h want 1/%h/0", instr_valid, instr, pc, I0); end
      tick();                                   // T4
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'd4 || instr_count !== 16'd1 || mem_rd !== 1'b1 || mem_addr !== 8'd1) begin
         n_bad++; $display("FAIL basic_T4: got vld=%b pc=%h cnt=%0d rd=%b addr=%h want 0/4/1/1/1",
                           instr_valid, pc, instr_count, mem_rd, mem_addr); end
      tick(); tick();                           // T6
      n_cmp++; if (instr_valid !== 1'b1 || instr !== I1 || pc !== 10'd4) begin
         n_bad++; $display("FAIL basic_T6_word1: got vld=%b instr=%h pc=%h want 1/%h/4", instr_valid, instr, pc, I1); end
      tick(); tick();                           // T8
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'd8) begin
         n_bad++; $display("FAIL basic_T8: got vld=%b pc=%h want 0/8", instr_valid, pc); end
      tick();                                   // T9
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || pc !== 10'd8 || instr_count !== 16'd2) begin
         n_bad++; $display("FAIL basic_halt: got halted=%b busy=%b vld=%b pc=%h cnt=%0d want 1/0/0/8/2",
                           halted, busy, instr_valid, pc, instr_count); end
   endtask

   task automatic test_restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (pc !== 10'd0 || halted !== 1'b0 || mem_rd !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL restart: got pc=%h halted=%b rd=%b busy=%b want 0/0/1/1", pc, halted, mem_rd, busy); end
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (halted !== 1'b1 || instr_count !== 16'd4) begin
         n_bad++; $display("FAIL restart_count: got halted=%b cnt=%0d want 1/4", halted, instr_count); end
      do_reset();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0 || halted !== 1'b0) begin
         n_bad++; $display("FAIL start_stop_idle: got busy=%b rd=%b halted=%b want 0/0/0", busy, mem_rd, halted); end
      tick();
      n_cmp++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL start_stop_idle2: got rd=%b busy=%b want 0/0", mem_rd, busy); end
   endtask

   task automatic test_backpressure();
      do_reset();
      ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();                           // HOLD, ready low (1st cycle)
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (instr_valid !== 1'b1 || instr !== I0 || pc !== 10'd0) begin
            n_bad++; $display("FAIL bp_stable_%0d: got vld=%b instr=%h pc=%h want 1/%h/0", i, instr_valid, instr, pc, I0); end
      end
      tick();
      ready = 1'b1;
      n_cmp++; if (instr_valid !== 1'b1 || instr_count !== 16'd0) begin
         n_bad++; $display("FAIL bp_before_accept: got vld=%b cnt=%0d want 1/0", instr_valid, instr_count); end
      tick();
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'd4 || instr_count !== 16'd1 || mem_rd !== 1'b1) begin
         n_bad++; $display("FAIL bp_accept: got vld=%b pc=%h cnt=%0d rd=%b want 0/4/1/1", instr_valid, pc, instr_count, mem_rd); end
      tick(); tick();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== I1 || pc !== 10'd4) begin
         n_bad++; $display("FAIL bp_next: got vld=%b instr=%h pc=%h want 1/%h/4", instr_valid, instr, pc, I1); end
   endtask

   task automatic test_stop();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();                                   // WAIT
      stop = 1'b1;
      tick();                                   // HOLD
      stop = 1'b0;
      n_cmp++; if (instr_valid !== 1'b1 || instr !== I0 || pc !== 10'd0) begin
         n_bad++; $display("FAIL stop_present: got vld=%b instr=%h pc=%h want 1/%h/0", instr_valid, instr, pc, I0); end
      tick();
      n_cmp++; if (busy !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || pc !== 10'd4 || instr_count !== 16'd1) begin
         n_bad++; $display("FAIL stop_idle: got busy=%b vld=%b halted=%b pc=%h cnt=%0d want 0/0/0/4/1",
                           busy, instr_valid, halted, pc, instr_count); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL stop_no_rd_%0d: got rd=%b busy=%b want 0/0", i, mem_rd, busy); end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_pc;
      logic [1:0] exp_addr;
      do_reset();
      w_start = 1'b1;
      tick();
      w_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); tick();
         exp_pc = 4'(k * 4);
         n_cmp++; if (w_valid !== 1'b1 || w_pc !== exp_pc || w_instr !== wmem[k]) begin
            n_bad++; $display("FAIL wrap_hold_%0d: got vld=%b pc=%h instr=%h want 1/%h/%h", k, w_valid, w_pc, w_instr, exp_pc, wmem[k]); end
         tick();
         exp_pc = 4'((k + 1) * 4);
         exp_addr = 2'(k + 1);
         n_cmp++; if (w_mem_rd !== 1'b1 || w_pc !== exp_pc || w_mem_addr !== exp_addr) begin
            n_bad++; $display("FAIL wrap_req_%0d: got rd=%b pc=%h addr=%h want 1/%h/%h", k, w_mem_rd, w_pc, w_mem_addr, exp_pc, exp_addr); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();                                   // WAIT
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({mem_rd, instr_valid, busy, halted} !== 4'b0000 || pc !== 10'd0 || instr !== 32'd0 || instr_count !== 16'd0) begin
         n_bad++; $display("FAIL rst_wait: got flags=%b pc=%h instr=%h cnt=%0d want 0000/0/0/0",
                           {mem_rd, instr_valid, busy, halted}, pc, instr, instr_count); end
      ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();                           // HOLD
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({mem_rd, instr_valid, busy, halted} !== 4'b0000 || pc !== 10'd0 || instr !== 32'd0 || mem_addr !== 8'd0) begin
         n_bad++; $display("FAIL rst_hold: got flags=%b pc=%h instr=%h addr=%h want 0000/0/0/0",
                           {mem_rd, instr_valid, busy, halted}, pc, instr, mem_addr); end
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'd0) begin
         n_bad++; $display("FAIL rst_refetch_rd: got rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
      tick(); tick();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== I0 || pc !== 10'd0) begin
         n_bad++; $display("FAIL rst_refetch: got vld=%b instr=%h pc=%h want 1/%h/0", instr_valid, instr, pc, I0); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0] = I0;
      mem[1] = I1;
      mem[2] = HALT;
      wmem[0] = 32'hA000_0001;
      wmem[1] = 32'hA000_0002;
      wmem[2] = 32'hA000_0003;
      wmem[3] = 32'hA000_0004;

      test_reset();
      test_basic();
      test_restart();
      test_backpressure();
      test_stop();
      test_wrap();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
